// File: rtl/cache_control_pkg.sv
// Shared types and geometry for the 2-way, 8-set, 16-byte-line cache controller.
// cache_state_t encodes the three controller states.
package cache_control_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  localparam int NUM_WAYS  = 2;
  localparam int NUM_SETS  = 8;
  localparam int INDEX_MSB = 6;
  localparam int INDEX_LSB = 4;
  localparam int INDEX_W   = INDEX_MSB - INDEX_LSB + 1;

  typedef logic [INDEX_W-1:0] cache_index_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE
  } cache_state_t;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic lc3b_word sat_inc(input lc3b_word value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cache_control_if.sv
// Controller-facing signal bundle: CPU request, datapath status, pmem handshake, array enables.
// master = the controller, slave = the CPU/datapath/memory environment around it.
interface cache_control_if;
  import cache_control_pkg::*;

  logic     mem_read;
  logic     mem_write;
  lc3b_word mem_address;
  logic     mem_resp;

  logic     hit0;
  logic     hit1;
  logic     valid0;
  logic     valid1;
  logic     dirty0;
  logic     dirty1;

  logic     pmem_read;
  logic     pmem_write;
  logic     pmem_resp;

  logic     way_sel;
  logic     load_data;
  logic     load_tag;
  logic     set_valid;
  logic     set_dirty;
  logic     clr_dirty;
  logic     data_src;
  logic     paddr_src;

  lc3b_word hit_count;
  lc3b_word miss_count;

  modport master (
    input  mem_read, mem_write, mem_address,
    input  hit0, hit1, valid0, valid1, dirty0, dirty1,
    input  pmem_resp,
    output mem_resp, pmem_read, pmem_write,
    output way_sel, load_data, load_tag, set_valid, set_dirty, clr_dirty,
    output data_src, paddr_src,
    output hit_count, miss_count
  );

  modport slave (
    output mem_read, mem_write, mem_address,
    output hit0, hit1, valid0, valid1, dirty0, dirty1,
    output pmem_resp,
    input  mem_resp, pmem_read, pmem_write,
    input  way_sel, load_data, load_tag, set_valid, set_dirty, clr_dirty,
    input  data_src, paddr_src,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/cache_control_lru.sv
// Per-set LRU bit: value names the way to evict next. One bit per set,
// asynchronously cleared, combinational read by index, single write port.
module cache_lru
  import cache_control_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  cache_index_t rd_index,
  output logic         rd_value,
  input  cache_index_t wr_index,
  input  logic         wr_value,
  input  logic         wr_en
);

  logic lru_reg [NUM_SETS];

  generate
    for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lru_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_index == cache_index_t'(gi))) begin
          lru_reg[gi] <= wr_value;
        end
      end
    end
  endgenerate

  assign rd_value = lru_reg[rd_index];

endmodule

// File: rtl/cache_control.sv
// Cache controller FSM: zero-wait hits in IDLE, write-back of dirty victims,
// line allocation from physical memory, LRU replacement and saturating hit/miss counters.
module cache_control
  import cache_control_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  cache_control_if.master bus
);

  cache_state_t state_reg;
  logic         victim_reg;
  lc3b_word     hit_count_reg;
  lc3b_word     miss_count_reg;

  cache_index_t index;
  logic         request;
  logic         any_hit;
  logic         hit_way;
  logic         lru_way;
  logic         victim_next;
  logic         victim_dirty;
  logic         lru_wr_en;
  logic         unused_addr_bits;

  assign index            = bus.mem_address[INDEX_MSB:INDEX_LSB];
  assign unused_addr_bits = ^{bus.mem_address[15:INDEX_MSB+1], bus.mem_address[INDEX_LSB-1:0]};
  assign request          = bus.mem_read | bus.mem_write;
  assign any_hit          = bus.hit0 | bus.hit1;
  assign hit_way          = ~bus.hit0;

  // Empty ways are filled first; only a full set consults the LRU bit.
  assign victim_next  = !bus.valid0 ? 1'b0 : (!bus.valid1 ? 1'b1 : lru_way);
  assign victim_dirty = bus.valid0 & bus.valid1 & (lru_way ? bus.dirty1 : bus.dirty0);
  assign lru_wr_en    = (state_reg == S_IDLE) && request && any_hit;

  cache_lru u_lru (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (index),
    .rd_value (lru_way),
    .wr_index (index),
    .wr_value (~hit_way),
    .wr_en    (lru_wr_en)
  );

  // Outputs are decoded from state and inputs; reset forces every one of them low.
  always_comb begin
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.way_sel    = 1'b0;
    bus.load_data  = 1'b0;
    bus.load_tag   = 1'b0;
    bus.set_valid  = 1'b0;
    bus.set_dirty  = 1'b0;
    bus.clr_dirty  = 1'b0;
    bus.data_src   = 1'b0;
    bus.paddr_src  = 1'b0;
    if (rst_n) begin
      case (state_reg)
        S_IDLE: begin
          if (request && any_hit) begin
            bus.mem_resp = 1'b1;
            bus.way_sel  = hit_way;
            if (bus.mem_write) begin
              bus.load_data = 1'b1;
              bus.set_dirty = 1'b1;
            end
          end
        end
        S_WRITEBACK: begin
          bus.pmem_write = 1'b1;
          bus.paddr_src  = 1'b1;
          bus.way_sel    = victim_reg;
        end
        S_ALLOCATE: begin
          bus.pmem_read = 1'b1;
          bus.way_sel   = victim_reg;
          if (bus.pmem_resp) begin
            bus.load_data = 1'b1;
            bus.data_src  = 1'b1;
            bus.load_tag  = 1'b1;
            bus.set_valid = 1'b1;
            bus.clr_dirty = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      victim_reg     <= 1'b0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (request) begin
            if (any_hit) begin
              hit_count_reg <= sat_inc(hit_count_reg);
            end else begin
              victim_reg     <= victim_next;
              miss_count_reg <= sat_inc(miss_count_reg);
              state_reg      <= victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          // An abandoned request still finishes the write-back, then gives up.
          if (bus.pmem_resp) begin
            state_reg <= request ? S_ALLOCATE : S_IDLE;
          end
        end
        S_ALLOCATE: begin
          if (bus.pmem_resp) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.hit_count  = hit_count_reg;
  assign bus.miss_count = miss_count_reg;

endmodule
